// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO. Packets longer than DEPTH fall back to cut-through.
// Latency: a packet's first beat appears on m_* the cycle after its tlast beat is pushed.
// Backpressure: s_tready=0 only while DEPTH beats are stored. m_tvalid holds until the head beat is popped.
// Ports: CLK, RST_N (synchronous, active-low); s_t* beat input with s_tready;
//        m_t* head-beat output with m_tready; occupancy, pkt_count, and sticky oversize status.
module axis_packet_fifo #(
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int DEST_W = 4,
    parameter int USER_W = 4,
    parameter int DEPTH  = 32
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [DATA_W-1:0]            s_tdata,
    input  logic [DATA_W/8-1:0]          s_tstrb,
    input  logic [DATA_W/8-1:0]          s_tkeep,
    input  logic                         s_tlast,
    input  logic [ID_W-1:0]              s_tid,
    input  logic [DEST_W-1:0]            s_tdest,
    input  logic [USER_W-1:0]            s_tuser,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [DATA_W/8-1:0]          m_tstrb,
    output logic [DATA_W/8-1:0]          m_tkeep,
    output logic                         m_tlast,
    output logic [ID_W-1:0]              m_tid,
    output logic [DEST_W-1:0]            m_tdest,
    output logic [USER_W-1:0]            m_tuser,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic                         oversize
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int EW     = DATA_W + 2 * KEEP_W + 1 + ID_W + DEST_W + USER_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          cut_through;
    // Set once the oversized packet's own tlast beat has been written. Any later
    // tlast pushed during cut-through belongs to a following packet and must be counted.
    logic          tail_in;
    logic          push;
    logic          pop;
    logic          cnt_inc;
    logic          cnt_dec;

    assign s_tready = (occupancy != FULL);
    assign m_tvalid = (occupancy != '0) & ((pkt_count != '0) | cut_through);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = mem[rd_ptr];

    // The oversized packet never counts as a complete packet. Its tlast is neither
    // added on push nor removed on pop.
    assign cnt_inc = push & s_tlast & ~(cut_through & ~tail_in);
    assign cnt_dec = pop & m_tlast & ~cut_through;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            pkt_count   <= '0;
            cut_through <= 1'b0;
            tail_in     <= 1'b0;
            oversize    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push & ~pop)      occupancy <= occupancy + 1'b1;
            else if (pop & ~push) occupancy <= occupancy - 1'b1;

            if (cnt_inc & ~cnt_dec)      pkt_count <= pkt_count + 1'b1;
            else if (cnt_dec & ~cnt_inc) pkt_count <= pkt_count - 1'b1;

            if (cut_through) begin
                // While in cut-through, the head packet is the oversized one, so the
                // first tlast popped ends cut-through.
                if (pop & m_tlast) begin
                    cut_through <= 1'b0;
                    tail_in     <= 1'b0;
                end else if (push & s_tlast) begin
                    tail_in     <= 1'b1;
                end
            end else if ((occupancy == FULL) && (pkt_count == '0)) begin
                // The FIFO is full and holds only one partial packet. Without cut-through
                // that packet could never complete, so the FIFO would deadlock.
                cut_through <= 1'b1;
                oversize    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
module tb_axis_packet_fifo;

    localparam int DEPTH = 32;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [3:0]  user;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    beat_t       sb = '0;
    beat_t       mb;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tstrb, m_tkeep;
    logic        m_tlast;
    logic [3:0]  m_tid, m_tdest, m_tuser;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [5:0]  occupancy, pkt_count;
    logic        oversize;

    always #5 CLK = ~CLK;

    axis_packet_fifo #(.DATA_W(64), .ID_W(4), .DEST_W(4), .USER_W(4), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .s_tdata(sb.data), .s_tstrb(sb.strb), .s_tkeep(sb.keep), .s_tlast(sb.last),
        .s_tid(sb.id), .s_tdest(sb.dest), .s_tuser(sb.user),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .occupancy(occupancy), .pkt_count(pkt_count), .oversize(oversize)
    );

    assign mb = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};

    int    checks = 0;
    int    errors = 0;
    beat_t src[$];
    beat_t mq[$];
    bit    m_ct = 0;
    bit    m_ovs = 0;
    int    rdy_mode = 0;
    bit    gaps = 0;
    logic  a_vld, a_srdy, a_ovs, e_vld, e_srdy, e_ovs;
    logic [5:0] a_occ, a_pkt, e_occ, e_pkt;
    bit    did_push, did_pop;
    beat_t got, exp_b, pushed_b;

    function automatic beat_t mk(logic [63:0] d, logic last, logic [3:0] id, logic [3:0] dest);
        beat_t b;
        b.data = d; b.last = last; b.id = id; b.dest = dest;
        b.strb = 8'($urandom); b.keep = 8'($urandom); b.user = 4'($urandom);
        return b;
    endfunction

    function automatic int nlast();
        int n = 0;
        foreach (mq[i]) if (mq[i].last) n++;
        return n;
    endfunction

    task automatic drive();
        s_tvalid = (src.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        sb = (src.size() > 0) ? src[0] : '0;
        case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock cycle. Sample the DUT at the negedge and compute the expected
    // view from the beat queue. After the edge, apply push/pop to the queue.
    task automatic tick();
        int nl;
        bit enter;
        beat_t tmp;
        @(negedge CLK);
        a_vld = m_tvalid; a_srdy = s_tready; a_ovs = oversize;
        a_occ = occupancy; a_pkt = pkt_count; got = mb;
        nl = nlast();
        e_occ  = 6'(mq.size());
        // In cut-through mode, the first tlast in the queue ends the oversized packet, which is not counted.
        e_pkt  = 6'((m_ct && nl > 0) ? nl - 1 : nl);
        e_vld  = (mq.size() > 0) && (m_ct || nl > 0);
        e_srdy = (mq.size() != DEPTH);
        e_ovs  = m_ovs;
        did_push = RST_N && s_tvalid && e_srdy;
        did_pop  = RST_N && m_tready && e_vld;
        pushed_b = sb;
        exp_b    = did_pop ? mq[0] : '0;
        @(posedge CLK);
        if (!RST_N) begin
            mq.delete(); m_ct = 0; m_ovs = 0;
        end else begin
            enter = !m_ct && (mq.size() == DEPTH) && (nl == 0);
            if (did_pop) begin
                tmp = mq.pop_front();
                if (m_ct && tmp.last) m_ct = 0;
            end
            if (did_push) mq.push_back(src.pop_front());
            if (enter) begin m_ct = 1; m_ovs = 1; end
        end
        #1 drive();
    endtask

    task automatic test_reset();
        RST_N = 1'b0; drive();
        tick(); tick();
        RST_N = 1'b1;
        tick();
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset m_tvalid: got %b need 0", a_vld); end
        checks++; if (a_srdy !== 1'b1) begin errors++; $display("FAIL reset s_tready: got %b need 1", a_srdy); end
        checks++; if (a_occ !== 6'd0) begin errors++; $display("FAIL reset occupancy: got %0d need 0", a_occ); end
        checks++; if (a_pkt !== 6'd0) begin errors++; $display("FAIL reset pkt_count: got %0d need 0", a_pkt); end
        checks++; if (a_ovs !== 1'b0) begin errors++; $display("FAIL reset oversize: got %b need 0", a_ovs); end
    endtask

    task automatic test_single();
        int n = 0, npop = 0, push_t = -1, vld_t = -1;
        logic [5:0] pkt_at_vld = '0;
        for (int i = 0; i < 24; i++) src.push_back(mk(64'hdeadbeef00000000 + 64'(i), i == 23, 4'd2, 4'd5));
        rdy_mode = 1; gaps = 0; drive();
        while ((src.size() > 0 || mq.size() > 0) && n < 200) begin
            tick(); n++;
            checks++;
            if ({a_vld, a_srdy, a_ovs, a_occ, a_pkt} !== {e_vld, e_srdy, e_ovs, e_occ, e_pkt}) begin
                errors++;
                $display("FAIL single status: got vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d need vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d",
                         a_vld, a_srdy, a_ovs, a_occ, a_pkt, e_vld, e_srdy, e_ovs, e_occ, e_pkt);
            end
            if (a_vld === 1'b1 && vld_t < 0) begin vld_t = n; pkt_at_vld = a_pkt; end
            if (did_push && pushed_b.last) push_t = n;
            if (did_pop) begin
                checks++;
                if (got !== exp_b || got.data !== 64'hdeadbeef00000000 + 64'(npop) || got.id !== 4'd2 || got.dest !== 4'd5) begin
                    errors++; $display("FAIL single beat %0d: got %h need %h", npop, got, exp_b);
                end
                npop++;
            end
        end
        if (n >= 200) begin errors++; $display("FAIL single timeout: %0d beats left", src.size() + mq.size()); end
        checks++; if (vld_t != push_t + 1) begin errors++; $display("FAIL single latency: m_tvalid rose at %0d need %0d", vld_t, push_t + 1); end
        checks++; if (pkt_at_vld !== 6'd1) begin errors++; $display("FAIL single pkt_count at visibility: got %0d need 1", pkt_at_vld); end
        tick();
        checks++;
        if (a_occ !== 6'd0 || a_pkt !== 6'd0 || a_vld !== 1'b0) begin
            errors++; $display("FAIL single drained: got occ=%0d pkt=%0d vld=%b need 0 0 0", a_occ, a_pkt, a_vld);
        end
    endtask

    task automatic test_backpressure();
        int n = 0, npop = 0;
        for (int i = 0; i < 32; i++) src.push_back(mk(64'h00b0_0000_0000_0000 + 64'(i), 1'b1, 4'(i), 4'(i + 3)));
        rdy_mode = 0; gaps = 0; drive();
        while (src.size() > 0 && n < 100) begin
            tick(); n++;
            checks++;
            if ({a_vld, a_srdy, a_ovs, a_occ, a_pkt} !== {e_vld, e_srdy, e_ovs, e_occ, e_pkt}) begin
                errors++;
                $display("FAIL backpressure fill status: got vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d need vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d",
                         a_vld, a_srdy, a_ovs, a_occ, a_pkt, e_vld, e_srdy, e_ovs, e_occ, e_pkt);
            end
        end
        tick();
        checks++;
        if (a_srdy !== 1'b0 || a_occ !== 6'd32 || a_pkt !== 6'd32) begin
            errors++; $display("FAIL backpressure full: got rdy=%b occ=%0d pkt=%0d need 0 32 32", a_srdy, a_occ, a_pkt);
        end
        rdy_mode = 1; drive();
        n = 0;
        while (mq.size() > 0 && n < 100) begin
            tick(); n++;
            checks++;
            if ({a_vld, a_srdy, a_ovs, a_occ, a_pkt} !== {e_vld, e_srdy, e_ovs, e_occ, e_pkt}) begin
                errors++;
                $display("FAIL backpressure drain status: got vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d need vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d",
                         a_vld, a_srdy, a_ovs, a_occ, a_pkt, e_vld, e_srdy, e_ovs, e_occ, e_pkt);
            end
            if (n == 2) begin
                checks++; if (a_srdy !== 1'b1) begin errors++; $display("FAIL backpressure s_tready after first pop: got %b need 1", a_srdy); end
            end
            if (did_pop) begin
                checks++;
                if (got !== exp_b || got.data !== 64'h00b0_0000_0000_0000 + 64'(npop)) begin
                    errors++; $display("FAIL backpressure beat %0d: got %h need %h", npop, got, exp_b);
                end
                npop++;
            end
        end
        if (n >= 100) begin errors++; $display("FAIL backpressure timeout: %0d beats left", mq.size()); end
        checks++; if (npop != 32) begin errors++; $display("FAIL backpressure pops: got %0d need 32", npop); end
    endtask

    task automatic test_simul();
        int n = 0, both_t = -1;
        for (int i = 0; i < 8; i++) src.push_back(mk(64'(i) + 64'h5100, i == 3 || i == 7, 4'd1, 4'd7));
        rdy_mode = 1; gaps = 0; drive();
        while ((src.size() > 0 || mq.size() > 0) && n < 100) begin
            tick(); n++;
            checks++;
            if ({a_vld, a_srdy, a_ovs, a_occ, a_pkt} !== {e_vld, e_srdy, e_ovs, e_occ, e_pkt}) begin
                errors++;
                $display("FAIL simul status: got vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d need vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d",
                         a_vld, a_srdy, a_ovs, a_occ, a_pkt, e_vld, e_srdy, e_ovs, e_occ, e_pkt);
            end
            if (n >= 5 && n <= 9) begin
                checks++; if (a_occ !== 6'd4) begin errors++; $display("FAIL simul occupancy tick %0d: got %0d need 4", n, a_occ); end
            end
            if (both_t >= 0 && n == both_t + 1) begin
                checks++; if (a_pkt !== 6'd1) begin errors++; $display("FAIL simul pkt_count hold: got %0d need 1", a_pkt); end
            end
            if (did_pop) begin
                checks++; if (got !== exp_b) begin errors++; $display("FAIL simul beat: got %h need %h", got, exp_b); end
            end
            if (did_push && pushed_b.last && did_pop && exp_b.last) both_t = n;
        end
        if (n >= 100 || both_t < 0) begin errors++; $display("FAIL simul coincidence: both_t=%0d ticks=%0d", both_t, n); end
    endtask

    task automatic test_oversize();
        int n = 0, npop = 0, npush = 0, ovs_t = -1, push_t = -1, vld_t = -1;
        for (int i = 0; i < 40; i++) src.push_back(mk(64'h0a00_0000_0000_0000 + 64'(i), i == 39, 4'd9, 4'd3));
        rdy_mode = 1; gaps = 0; drive();
        while ((src.size() > 0 || mq.size() > 0) && n < 300) begin
            tick(); n++;
            checks++;
            if ({a_vld, a_srdy, a_ovs, a_occ, a_pkt} !== {e_vld, e_srdy, e_ovs, e_occ, e_pkt}) begin
                errors++;
                $display("FAIL oversize status: got vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d need vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d",
                         a_vld, a_srdy, a_ovs, a_occ, a_pkt, e_vld, e_srdy, e_ovs, e_occ, e_pkt);
            end
            if (a_ovs === 1'b1 && ovs_t < 0) begin
                ovs_t = n;
                checks++;
                if (a_vld !== 1'b1 || npush != 32) begin
                    errors++; $display("FAIL oversize entry: got vld=%b after %0d pushes need vld=1 after 32", a_vld, npush);
                end
            end
            if (did_push) npush++;
            if (did_pop) begin
                checks++;
                if (got !== exp_b || got.data !== 64'h0a00_0000_0000_0000 + 64'(npop)) begin
                    errors++; $display("FAIL oversize beat %0d: got %h need %h", npop, got, exp_b);
                end
                npop++;
            end
        end
        if (n >= 300) begin errors++; $display("FAIL oversize timeout: %0d beats left", src.size() + mq.size()); end
        tick();
        checks++;
        if (a_pkt !== 6'd0 || a_vld !== 1'b0 || a_ovs !== 1'b1 || a_occ !== 6'd0) begin
            errors++; $display("FAIL oversize end: got pkt=%0d vld=%b ovs=%b occ=%0d need 0 0 1 0", a_pkt, a_vld, a_ovs, a_occ);
        end
        for (int i = 0; i < 3; i++) src.push_back(mk(64'h0c00 + 64'(i), i == 2, 4'd4, 4'd4));
        drive(); n = 0;
        while ((src.size() > 0 || mq.size() > 0) && n < 100) begin
            tick(); n++;
            checks++;
            if ({a_vld, a_srdy, a_ovs, a_occ, a_pkt} !== {e_vld, e_srdy, e_ovs, e_occ, e_pkt}) begin
                errors++;
                $display("FAIL post-oversize status: got vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d need vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d",
                         a_vld, a_srdy, a_ovs, a_occ, a_pkt, e_vld, e_srdy, e_ovs, e_occ, e_pkt);
            end
            if (a_vld === 1'b1 && vld_t < 0) vld_t = n;
            if (did_push && pushed_b.last) push_t = n;
            if (did_pop) begin
                checks++; if (got !== exp_b) begin errors++; $display("FAIL post-oversize beat: got %h need %h", got, exp_b); end
            end
        end
        checks++; if (vld_t != push_t + 1) begin errors++; $display("FAIL post-oversize store-forward: vld at %0d need %0d", vld_t, push_t + 1); end
    endtask

    task automatic test_wrap();
        int n = 0, npop = 0;
        for (int p = 0; p < 10; p++)
            for (int b = 0; b < 7; b++)
                src.push_back(mk(64'h7000 + 64'(p * 7 + b), b == 6, 4'(p), 4'(15 - p)));
        rdy_mode = 2; gaps = 1; drive();
        while ((src.size() > 0 || mq.size() > 0) && n < 2000) begin
            tick(); n++;
            checks++;
            if ({a_vld, a_srdy, a_ovs, a_occ, a_pkt} !== {e_vld, e_srdy, e_ovs, e_occ, e_pkt}) begin
                errors++;
                $display("FAIL wrap status: got vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d need vld=%b rdy=%b ovs=%b occ=%0d pkt=%0d",
                         a_vld, a_srdy, a_ovs, a_occ, a_pkt, e_vld, e_srdy, e_ovs, e_occ, e_pkt);
            end
            if (did_pop) begin
                checks++;
                if (got !== exp_b || got.data !== 64'h7000 + 64'(npop)) begin
                    errors++; $display("FAIL wrap beat %0d: got %h need %h", npop, got, exp_b);
                end
                npop++;
            end
        end
        if (n >= 2000) begin errors++; $display("FAIL wrap timeout: %0d beats left", src.size() + mq.size()); end
        checks++; if (npop != 70) begin errors++; $display("FAIL wrap pops: got %0d need 70", npop); end
        rdy_mode = 1; gaps = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0, np = 0;
        for (int i = 0; i < 24; i++) src.push_back(mk(64'hbad0_0000_0000_0000 + 64'(i), i == 23, 4'd6, 4'd6));
        rdy_mode = 1; gaps = 0; drive();
        while (np < 5 && n < 50) begin tick(); n++; if (did_push) np++; end
        src.delete(); RST_N = 1'b0; drive();
        tick();
        RST_N = 1'b1;
        tick();
        checks++;
        if (a_occ !== 6'd0 || a_pkt !== 6'd0 || a_vld !== 1'b0 || a_srdy !== 1'b1 || a_ovs !== 1'b0) begin
            errors++; $display("FAIL reset_mid state: got occ=%0d pkt=%0d vld=%b rdy=%b ovs=%b need 0 0 0 1 0",
                               a_occ, a_pkt, a_vld, a_srdy, a_ovs);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_mid stale: m_tvalid=%b data=%h need 0", a_vld, got.data); end
        end
        for (int i = 0; i < 2; i++) src.push_back(mk(64'h600d + 64'(i), i == 1, 4'd8, 4'd1));
        drive(); n = 0; np = 0;
        while ((src.size() > 0 || mq.size() > 0) && n < 100) begin
            tick(); n++;
            if (did_pop) begin
                checks++;
                if (got !== exp_b || got.data !== 64'h600d + 64'(np)) begin
                    errors++; $display("FAIL reset_mid fresh beat %0d: got %h need %h", np, got, exp_b);
                end
                np++;
            end
        end
        checks++; if (np != 2) begin errors++; $display("FAIL reset_mid fresh pops: got %0d need 2", np); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_simul();
        test_oversize();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
